// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit SLL/SRL/SRA unit. The operand is shifted
// through the power-of-two stages 16, 8, 4, 2, 1, one stage per cycle.
// Build option: SHIFT_SEQ_SKIP_EN visits only the stages whose shamt bit is set.
// By default all five stages are visited.
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          request handshake carrying in_a, in_shamt, in_op
//   in_op                      00 SLL, 01 SRL, 10 SRA, 11 reserved (passes in_a)
//   out_valid/out_ready        result handshake carrying out_result
//   busy                       high whenever the unit is not idle
module shift_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STAGE_W = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [STAGE_W-1:0] TOP_STAGE = STAGE_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [DATA_W-1:0]    work_q,      work_d;
  logic [SHAMT_W-1:0]   pending_q,   pending_d;
  logic [1:0]           op_q,        op_d;
  logic                 sign_q,      sign_d;
  logic [STAGE_W-1:0]   k_q,         k_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q,      busy_d;

  // Apply one shift stage of 2^k; the reserved op leaves the operand unchanged.
  function automatic logic [DATA_W-1:0] apply_stage(
    input logic [DATA_W-1:0]  w,
    input logic [STAGE_W-1:0] k,
    input logic [1:0]         op,
    input logic               sign
  );
    logic [SHAMT_W-1:0] amt;
    logic [DATA_W-1:0]  fill_mask;
    logic [DATA_W-1:0]  res;
    amt       = SHAMT_W'(1) << k;
    fill_mask = ~({DATA_W{1'b1}} >> amt);
    case (op)
      OP_SLL:  res = w << amt;
      OP_SRL:  res = w >> amt;
      OP_SRA:  res = (w >> amt) | (fill_mask & {DATA_W{sign}});
      default: res = w;
    endcase
    return res;
  endfunction

`ifdef SHIFT_SEQ_SKIP_EN
  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [STAGE_W-1:0] msb_index(input logic [SHAMT_W-1:0] p);
    logic [STAGE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(SHAMT_W); i++) begin
      if (p[i]) idx = STAGE_W'(i);
    end
    return idx;
  endfunction
`endif

  // State registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      pending_q   <= '0;
      op_q        <= '0;
      sign_q      <= 1'b0;
      k_q         <= TOP_STAGE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      pending_q   <= pending_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    pending_d = pending_q;
    op_d      = op_q;
    sign_d    = sign_q;
    k_d       = k_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d    = in_a;
          pending_d = in_shamt;
          op_d      = in_op;
          sign_d    = in_a[DATA_W-1];
`ifdef SHIFT_SEQ_SKIP_EN
          k_d       = msb_index(in_shamt);
          state_d   = (in_shamt == '0) ? S_DONE : S_SHIFT;
`else
          k_d       = TOP_STAGE;
          state_d   = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
`ifdef SHIFT_SEQ_SKIP_EN
        // k_q always points at the highest pending bit here.
        work_d    = apply_stage(work_q, k_q, op_q, sign_q);
        pending_d = pending_q & ~(SHAMT_W'(1) << k_q);
        k_d       = msb_index(pending_d);
        if (pending_d == '0) state_d = S_DONE;
`else
        if (pending_q[k_q]) work_d = apply_stage(work_q, k_q, op_q, sign_q);
        if (k_q == '0) begin
          k_d     = TOP_STAGE;
          state_d = S_DONE;
        end else begin
          k_d     = k_q - STAGE_W'(1);
        end
`endif
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake flags are registered from the next state.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_result = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: directed vector table plus hand-written
// backpressure and mid-operation reset sequences.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shift_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Edges between the accept edge and the first out_valid sample.
  function automatic int exp_lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_SKIP_EN
    return $countones(s);
`else
    return 5;
`endif
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    check({tag, " ready_pre"}, {31'd0, in_ready}, 32'd1);
    in_a      = v.a;
    in_shamt  = v.shamt;
    in_op     = v.op;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a     = 32'hA5A5_A5A5;
    in_shamt = 5'd7;
    in_op    = 2'b01;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat(v.shamt)));
    check({tag, " result"}, out_result, v.exp);
    check({tag, " busy_done"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, " ready_post"}, {31'd0, in_ready}, 32'd1);
    check({tag, " valid_post"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    vec_t v;
    vecs[0]  = '{32'h0000_FFFF, 5'd16, 2'b00, 32'hFFFF_0000};
    vecs[1]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
    vecs[2]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
    vecs[3]  = '{32'h7FFF_FFF0, 5'd4,  2'b10, 32'h07FF_FFFF};
    vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF};
    vecs[5]  = '{32'h1234_5678, 5'd5,  2'b11, 32'h1234_5678};
    vecs[6]  = '{32'hF000_0000, 5'd4,  2'b01, 32'h0F00_0000};
    vecs[7]  = '{32'hF000_0000, 5'd4,  2'b10, 32'hFF00_0000};
    vecs[8]  = '{32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800};
    vecs[9]  = '{32'hDEAD_BEEF, 5'd31, 2'b01, 32'h0000_0001};
    vecs[10] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000};
    vecs[11] = '{32'h8765_4321, 5'd12, 2'b10, 32'hFFF8_7654};
    vecs[12] = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst in_ready",   {31'd0, in_ready},  32'd1);
    check("rst out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst busy",       {31'd0, busy},      32'd0);
    check("rst out_result", out_result,         32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold while out_ready is low; requests ignored.
    in_a      = 32'h0000_0001;
    in_shamt  = 5'd3;
    in_op     = 2'b00;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp latency", 32'(n), 32'(exp_lat(5'd3)));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a     = 32'hFFFF_0000 + 32'(i);
      in_shamt = 5'd1;
      tick();
      check($sformatf("bp%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d result", i),    out_result,         32'h0000_0008);
      check($sformatf("bp%0d in_ready", i),  {31'd0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp release in_ready",  {31'd0, in_ready},  32'd1);
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release busy",      {31'd0, busy},      32'd0);

    // Reset mid-operation discards the partial result; reset beats in_valid.
    in_a      = 32'h0000_0001;
    in_shamt  = 5'd31;
    in_op     = 2'b00;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mid busy", {31'd0, busy}, 32'd1);
    tick();
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mr out_valid",  {31'd0, out_valid}, 32'd0);
    check("mr busy",       {31'd0, busy},      32'd0);
    check("mr out_result", out_result,         32'h0);
    check("mr in_ready",   {31'd0, in_ready},  32'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    v = '{32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002};
    run_vec(v, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
